tt_tdc_meas_seq: RTL and testbench

//  Measurement sequencer for the pulse-generator/tapped-delay-line TDC. On start it

---
 rtl/tt_tdc_meas_seq.sv | 151 +++++++++++++++
 tb/tb_tt_tdc_meas_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_tdc_meas_seq.sv
// Measurement sequencer for the pulse-generator / tapped-delay-line TDC.
// Runs N launch/settle/capture/accumulate samples and reports the popcount sum.
module tt_tdc_meas_seq #(
    parameter int unsigned LEN_POP_OUT = 6,
    parameter int unsigned SETTLE_W    = 4,
    parameter int unsigned NSAMP_W     = 4,
    localparam int unsigned ACC_W      = LEN_POP_OUT + 1 + NSAMP_W
) (
    input  logic                   clk_launch,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [1:0]             cfg_sel,
    input  logic [NSAMP_W-1:0]     n_samples,
    input  logic [SETTLE_W-1:0]    settle_cycles,
    input  logic [LEN_POP_OUT:0]   pop_in,
    output logic [1:0]             sel,
    output logic                   pg_tog,
    output logic                   cap_en,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [ACC_W-1:0]       acc_out
);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StLaunch,
        StSettle,
        StCapture,
        StAccum,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [NSAMP_W-1:0]  cnt_q, cnt_d;
    logic [NSAMP_W-1:0]  n_q, n_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] scnt_q, scnt_d;

    logic [1:0]          sel_d;
    logic                pg_tog_d, cap_en_d, busy_d, done_d, aborted_d;
    logic [ACC_W-1:0]    acc_out_d;

    // Outputs are derived from the next state so they line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        settle_d  = settle_q;
        scnt_d    = scnt_q;
        sel_d     = sel;
        pg_tog_d  = pg_tog;
        cap_en_d  = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        acc_out_d = acc_out;

        if (state_q != StIdle && !en) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en && start) begin
                        sel_d    = cfg_sel;
                        settle_d = settle_cycles;
                        n_d      = (n_samples == '0) ? NSAMP_W'(1) : n_samples;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StArm;
                    end
                end
                StArm: begin
                    pg_tog_d = ~pg_tog;
                    state_d  = StLaunch;
                end
                StLaunch: begin
                    scnt_d  = settle_q;
                    state_d = StSettle;
                end
                StSettle: begin
                    if (scnt_q == '0) begin
                        cap_en_d = 1'b1;
                        state_d  = StCapture;
                    end else begin
                        scnt_d = scnt_q - SETTLE_W'(1);
                    end
                end
                StCapture: begin
                    state_d = StAccum;
                end
                StAccum: begin
                    acc_d = acc_q + ACC_W'(pop_in);
                    cnt_d = cnt_q + NSAMP_W'(1);
                    if (cnt_d == n_q) begin
                        done_d    = 1'b1;
                        acc_out_d = acc_d;
                        state_d   = StDone;
                    end else begin
                        state_d = StArm;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_launch) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
            settle_q <= '0;
            scnt_q   <= '0;
            sel      <= '0;
            pg_tog   <= 1'b0;
            cap_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            acc_out  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            settle_q <= settle_d;
            scnt_q   <= scnt_d;
            sel      <= sel_d;
            pg_tog   <= pg_tog_d;
            cap_en   <= cap_en_d;
            busy     <= busy_d;
            done     <= done_d;
            aborted  <= aborted_d;
            acc_out  <= acc_out_d;
        end
    end

endmodule

// File: tb/tb_tt_tdc_meas_seq.sv
// Self-checking bench for tt_tdc_meas_seq: schedule-based reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_tt_tdc_meas_seq;

    localparam int ACC_W = 11;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        cfg_sel = '0;
    logic [3:0]        n_samples = '0;
    logic [3:0]        settle_cycles = '0;
    logic [6:0]        pop_in = '0;
    logic [1:0]        sel;
    logic              pg_tog, cap_en, busy, done, aborted;
    logic [ACC_W-1:0]  acc_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    tt_tdc_meas_seq dut (
        .clk_launch    (clk),
        .rst           (rst),
        .en            (en),
        .start         (start),
        .cfg_sel       (cfg_sel),
        .n_samples     (n_samples),
        .settle_cycles (settle_cycles),
        .pop_in        (pop_in),
        .sel           (sel),
        .pg_tog        (pg_tog),
        .cap_en        (cap_en),
        .busy          (busy),
        .done          (done),
        .aborted       (aborted),
        .acc_out       (acc_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: a run is a schedule indexed by k cycles after the start cycle.
    // Sample j occupies k = 1 + j*(s+5) .. ; phase 0 arm, 1 launch, 3+s capture, 4+s accum.
    // Done falls at k = 1 + N*(s+5).
    bit         m_valid = 0;
    bit         m_active = 0;
    int         m_k, m_n, m_s, m_acc, total, ph;
    logic [1:0] e_sel;
    logic       e_pg, e_cap, e_busy, e_done, e_ab;
    int         e_acc_out;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1; m_active = 0;
            e_sel = '0; e_pg = 0; e_cap = 0; e_busy = 0; e_done = 0; e_ab = 0; e_acc_out = 0;
        end else if (m_valid) begin
            e_cap = 0; e_done = 0; e_ab = 0;
            if (!m_active) begin
                if (en && start) begin
                    m_active = 1; m_k = 1; m_acc = 0;
                    m_n = (n_samples == 0) ? 1 : int'(n_samples);
                    m_s = int'(settle_cycles);
                    e_sel = cfg_sel; e_busy = 1;
                end else begin
                    e_busy = 0;
                end
            end else begin
                total = 1 + m_n * (m_s + 5);
                if (!en) begin
                    m_active = 0; e_busy = 0; e_ab = 1;
                end else if (m_k == total) begin
                    m_active = 0; e_busy = 0;
                end else begin
                    if ((m_k - 1) % (m_s + 5) == m_s + 4) m_acc += int'(pop_in);
                    m_k++;
                    if (m_k == total) begin
                        e_done = 1; e_acc_out = m_acc;
                    end else begin
                        ph = (m_k - 1) % (m_s + 5);
                        if (ph == 1) e_pg = !e_pg;
                        e_cap = (ph == m_s + 3);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("sel", int'(sel), int'(e_sel));
            chk("pg_tog", int'(pg_tog), int'(e_pg));
            chk("cap_en", int'(cap_en), int'(e_cap));
            chk("busy", int'(busy), int'(e_busy));
            chk("done", int'(done), int'(e_done));
            chk("aborted", int'(aborted), int'(e_ab));
            chk("acc_out", int'(acc_out), e_acc_out);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Starts a run in the current idle cycle and waits (bounded) for done.
    task automatic do_run(input int n, input int s, input int pop, input logic [1:0] cfg,
                          output int done_k, output int cap_k, output int caps);
        int t;
        @(negedge clk);
        en = 1'b1; start = 1'b1; cfg_sel = cfg;
        n_samples = 4'(n); settle_cycles = 4'(s); pop_in = 7'(pop);
        t = cyc; done_k = -1; cap_k = -1; caps = 0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 400 && done_k < 0; i++) begin
            if (cap_en) begin
                caps++;
                if (cap_k < 0) cap_k = cyc - t;
            end
            if (done) done_k = cyc - t;
            if (done_k < 0) @(negedge clk);
        end
    endtask

    initial begin
        int dk, ck, cp, t;
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_pg", int'(pg_tog), 0);
        chk("rst_acc", int'(acc_out), 0);

        // 1: single sample, no settle
        do_run(1, 0, 37, 2'd1, dk, ck, cp);
        chk("t1_cap_k", ck, 4);
        chk("t1_done_k", dk, 6);
        chk("t1_acc", int'(acc_out), 37);
        chk("t1_pg", int'(pg_tog), 1);

        // 2: four samples, settle 3
        do_reset();
        do_run(4, 3, 64, 2'd2, dk, ck, cp);
        chk("t2_caps", cp, 4);
        chk("t2_cap_k", ck, 7);
        chk("t2_done_k", dk, 33);
        chk("t2_acc", int'(acc_out), 256);
        chk("t2_pg", int'(pg_tog), 0);

        // 3: maximum N without overflow; N=0 acts as 1
        do_run(15, 0, 64, 2'd3, dk, ck, cp);
        chk("t3_done_k", dk, 76);
        chk("t3_acc", int'(acc_out), 960);
        do_run(0, 0, 20, 2'd0, dk, ck, cp);
        chk("t3_n0_done_k", dk, 6);
        chk("t3_n0_acc", int'(acc_out), 20);

        // 4: abort during settle of sample 2
        do_run(1, 0, 37, 2'd1, dk, ck, cp);
        @(negedge clk);
        en = 1'b1; start = 1'b1; n_samples = 4'd3; settle_cycles = 4'd5; pop_in = 7'd10;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_to(t + 14);
        en = 1'b0;
        @(negedge clk);
        chk("t4_aborted", int'(aborted), 1);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_acc", int'(acc_out), 37);
        en = 1'b1;
        @(negedge clk);
        chk("t4_aborted_1cyc", int'(aborted), 0);

        // 5: start and cfg changes while busy are ignored
        @(negedge clk);
        en = 1'b1; start = 1'b1; cfg_sel = 2'd2; n_samples = 4'd2; settle_cycles = 4'd1;
        pop_in = 7'd5;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_to(t + 3);
        cfg_sel = 2'd1; n_samples = 4'd9; settle_cycles = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_sel_mid", int'(sel), 2);
        dk = -1;
        for (int i = 0; i < 100 && dk < 0; i++) begin
            if (done) dk = cyc - t;
            else @(negedge clk);
        end
        chk("t5_done_k", dk, 13);
        chk("t5_acc", int'(acc_out), 10);
        chk("t5_sel_end", int'(sel), 2);

        // 6: reset in capture
        @(negedge clk);
        en = 1'b1; start = 1'b1; cfg_sel = 2'd3; n_samples = 4'd1; settle_cycles = 4'd2;
        pop_in = 7'd50;
        t = cyc;
        @(negedge clk);
        start = 1'b0;
        wait_to(t + 6);
        chk("t6_cap", int'(cap_en), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_sel", int'(sel), 0);
        chk("t6_pg", int'(pg_tog), 0);
        chk("t6_cap_rst", int'(cap_en), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_aborted", int'(aborted), 0);
        chk("t6_acc", int'(acc_out), 0);

        // Randomized traffic, checked cycle by cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 399) == 0);
            en            = ($urandom_range(0, 59) != 0);
            start         = ($urandom_range(0, 5) == 0);
            cfg_sel       = 2'($urandom_range(0, 3));
            n_samples     = 4'($urandom_range(0, 4));
            settle_cycles = 4'($urandom_range(0, 3));
            pop_in        = 7'($urandom_range(0, 64));
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
